// File: rtl/hack_pkg.sv
// ---------------------------------------------------------------------------
// hack_pkg
// Shared constants and types for the instruction-fetch front end.
//   WORD_W       : instruction / program-counter width
//   ROM_ADDR_W   : instruction-ROM address width
//   FETCH_DEPTH  : default number of fetch-queue entries
//   fetch_entry_t: one queue entry, the instruction word and the PC it came from
// ---------------------------------------------------------------------------
package hack_pkg;

    localparam int WORD_W      = 16;
    localparam int ROM_ADDR_W  = 15;
    localparam int FETCH_DEPTH = 2;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small circular queue of fetched instructions with synchronous clear.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : drop every entry; push/pop in the same cycle are ignored
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to write
//   pop_i         : retire the head entry
//   head_o        : head entry, all zero when the queue is empty
//   count_o       : number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
    import hack_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // A push into a full queue is only legal when the head leaves in the same
    // cycle; this keeps count bounded even if the caller misbehaves.
    assign w_pop  = pop_i && !w_empty && !clear_i;
    assign w_push = push_i && !clear_i && (!w_full || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an empty queue never exposes it.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_i;
    end

    assign head_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetches instructions from a 1-cycle-latency ROM at the current PC and
// buffers them in a small queue for the decoder.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   pc_i           : current PC from the PC block
//   pc_inc_o       : ask the PC block to advance (high on every issue)
//   flush_i        : jump taken; drops queued and in-flight instructions
//   rom_en_o       : ROM read strobe
//   rom_addr_o     : ROM read address (low ROM_ADDR_W bits of the PC)
//   rom_data_i     : ROM data, one cycle after rom_en_o
//   instr_o        : head-of-queue instruction
//   instr_pc_o     : full 16-bit PC of instr_o
//   instr_valid_o  : head entry valid
//   instr_ready_i  : consumer takes the head entry
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int DEPTH      = hack_pkg::FETCH_DEPTH,
    parameter int ROM_ADDR_W = hack_pkg::ROM_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [15:0]           pc_i,
    output logic                  pc_inc_o,
    input  logic                  flush_i,
    output logic                  rom_en_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]           rom_data_i,
    output logic [15:0]           instr_o,
    output logic [15:0]           instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
);

    import hack_pkg::*;

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam int               OCC_W   = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(DEPTH);

    logic [CNT_W-1:0]      w_count;
    logic [OCC_W-1:0]      w_occ;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;

    logic                  r_inflight;
    logic [WORD_W-1:0]     r_inflight_pc;
    logic [ROM_ADDR_W-1:0] r_rom_addr;

    assign w_valid = (w_count != '0) && !flush_i;
    assign w_pop   = w_valid && instr_ready_i;

    // Slots already claimed once this cycle's pop is taken into account: the
    // queued entries plus the read still coming back from the ROM.
    assign w_occ = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);

    // rst_ni is part of the issue term so the ROM strobe and PC advance are
    // forced low while reset is held, not just after the next edge.
    assign w_issue = rst_ni && !flush_i && (w_occ < DEPTH_L);

    // The ROM answer lands one cycle after issue; a flush in that cycle
    // kills it before it reaches the queue.
    assign w_push             = r_inflight && !flush_i;
    assign w_push_entry.pc    = r_inflight_pc;
    assign w_push_entry.instr = rom_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rom_addr    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= pc_i;
                r_rom_addr    <= pc_i[ROM_ADDR_W-1:0];
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (flush_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign rom_en_o      = w_issue;
    assign pc_inc_o      = w_issue;
    // The address is live during an issue and otherwise keeps the last one.
    assign rom_addr_o    = w_issue ? pc_i[ROM_ADDR_W-1:0] : r_rom_addr;
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;
    assign instr_valid_o = w_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch with a behavioural PC block and ROM
// (ROM[n] = n ^ 16'hA5A5). Inputs change on the falling edge, outputs are
// sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc = 16'h0000;
    logic        pc_inc;
    logic        flush;
    logic        rom_en;
    logic [14:0] rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        ready;
    logic        ld;
    logic [15:0] ld_val;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(
        .DEPTH      (2),
        .ROM_ADDR_W (15)
    ) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pc_i          (pc),
        .pc_inc_o      (pc_inc),
        .flush_i       (flush),
        .rom_en_o      (rom_en),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (ready)
    );

    always #5 clk = ~clk;

    // PC block: a jump (flush) or a bench-forced load wins over increment.
    always @(posedge clk) begin
        if (flush || ld) pc <= ld_val;
        else if (pc_inc) pc <= pc + 16'd1;
    end

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 16'(rom_addr) ^ 16'hA5A5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] p,
                           input logic [15:0] i);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
        chk({tag, ".pc"},    32'(instr_pc),    32'(p));
        chk({tag, ".instr"}, 32'(instr),       32'(i));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rom_en"},   32'(rom_en),      32'd0);
        chk({tag, ".pc_inc"},   32'(pc_inc),      32'd0);
        chk({tag, ".rom_addr"}, 32'(rom_addr),    32'd0);
        chk({tag, ".valid"},    32'(instr_valid), 32'd0);
        chk({tag, ".instr"},    32'(instr),       32'd0);
        chk({tag, ".pc"},       32'(instr_pc),    32'd0);
    endtask

    // Reset the DUT for one edge while the PC block loads start_pc, then
    // release; returns at the sample point before the first fetch edge.
    task automatic do_reset(input logic [15:0] start_pc, input logic rdy);
        @(negedge clk);
        rst_n  = 1'b0;
        flush  = 1'b0;
        ld     = 1'b1;
        ld_val = start_pc;
        ready  = rdy;
        @(negedge clk);
        ld     = 1'b0;
        rst_n  = 1'b1;
        #1;
    endtask

    task automatic adv(input logic rdy, input logic fl, input logic [15:0] lv);
        @(negedge clk);
        ready  = rdy;
        flush  = fl;
        ld     = 1'b0;
        ld_val = lv;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        ready  = 1'b1;
        ld     = 1'b0;
        ld_val = 16'h0000;

        // Held in reset across a clock edge.
        #7;
        chk_zero("rst");

        // Streaming from PC 0 with ready held high.
        do_reset(16'h0000, 1'b1);
        chk("s0.rom_en",   32'(rom_en),      32'd1);
        chk("s0.pc_inc",   32'(pc_inc),      32'd1);
        chk("s0.rom_addr", 32'(rom_addr),    32'h0000);
        chk("s0.valid",    32'(instr_valid), 32'd0);
        adv(1'b1, 1'b0, 16'h0000);
        chk("s1.rom_addr", 32'(rom_addr),    32'h0001);
        chk("s1.valid",    32'(instr_valid), 32'd0);
        for (int k = 2; k < 8; k++) begin
            adv(1'b1, 1'b0, 16'h0000);
            chk_out($sformatf("s%0d", k), 1'b1, 16'(k - 2), 16'(k - 2) ^ 16'hA5A5);
            chk($sformatf("s%0d.rom_addr", k), 32'(rom_addr), 32'(k));
        end

        // Backpressure: queue fills to two, fetching stops.
        do_reset(16'h0000, 1'b0);
        adv(1'b0, 1'b0, 16'h0000);
        chk("bp1.rom_en",   32'(rom_en),   32'd1);
        adv(1'b0, 1'b0, 16'h0000);
        chk("bp2.rom_en",   32'(rom_en),   32'd0);
        chk("bp2.rom_addr", 32'(rom_addr), 32'h0001);
        chk_out("bp2", 1'b1, 16'h0000, 16'hA5A5);
        adv(1'b0, 1'b0, 16'h0000);
        chk("bp3.rom_en",   32'(rom_en),   32'd0);
        chk("bp3.pc_inc",   32'(pc_inc),   32'd0);
        adv(1'b0, 1'b0, 16'h0000);
        chk("bp4.rom_en",   32'(rom_en),   32'd0);
        chk("bp4.pc_inc",   32'(pc_inc),   32'd0);
        chk("bp4.rom_addr", 32'(rom_addr), 32'h0001);
        chk_out("bp4", 1'b1, 16'h0000, 16'hA5A5);
        adv(1'b1, 1'b0, 16'h0000);
        chk("bp5.rom_en",   32'(rom_en),   32'd1);
        chk("bp5.rom_addr", 32'(rom_addr), 32'h0002);
        chk_out("bp5", 1'b1, 16'h0000, 16'hA5A5);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("bp6", 1'b1, 16'h0001, 16'hA5A4);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("bp7", 1'b1, 16'h0002, 16'hA5A7);

        // Jump while PC 5 is being presented (PC 3 queued, PC 4 in flight).
        adv(1'b1, 1'b1, 16'h0100);
        chk("fl0.valid",  32'(instr_valid), 32'd0);
        chk("fl0.rom_en", 32'(rom_en),      32'd0);
        chk("fl0.pc_inc", 32'(pc_inc),      32'd0);
        adv(1'b1, 1'b0, 16'h0000);
        chk("fl1.rom_en",   32'(rom_en),      32'd1);
        chk("fl1.rom_addr", 32'(rom_addr),    32'h0100);
        chk("fl1.valid",    32'(instr_valid), 32'd0);
        adv(1'b1, 1'b0, 16'h0000);
        chk("fl2.valid",    32'(instr_valid), 32'd0);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("fl3", 1'b1, 16'h0100, 16'hA4A5);

        // Jump in a cycle that would otherwise push 0x0102 and pop 0x0101.
        adv(1'b1, 1'b1, 16'h0200);
        chk("fp0.valid",    32'(instr_valid), 32'd0);
        adv(1'b1, 1'b0, 16'h0000);
        chk("fp1.valid",    32'(instr_valid), 32'd0);
        chk("fp1.rom_addr", 32'(rom_addr),    32'h0200);
        adv(1'b1, 1'b0, 16'h0000);
        chk("fp2.valid",    32'(instr_valid), 32'd0);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("fp3", 1'b1, 16'h0200, 16'hA7A5);

        // Address truncation and 16-bit PC wrap.
        do_reset(16'h7FFF, 1'b1);
        chk("wr0.rom_addr", 32'(rom_addr), 32'h7FFF);
        ld     = 1'b1;
        ld_val = 16'hFFFF;
        adv(1'b1, 1'b0, 16'h0000);
        chk("wr1.rom_addr", 32'(rom_addr), 32'h7FFF);
        adv(1'b1, 1'b0, 16'h0000);
        chk("wr2.rom_addr", 32'(rom_addr), 32'h0000);
        chk_out("wr2", 1'b1, 16'h7FFF, 16'hDA5A);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("wr3", 1'b1, 16'hFFFF, 16'hDA5A);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("wr4", 1'b1, 16'h0000, 16'hA5A5);

        // Reset pulse between edges with the queue full.
        do_reset(16'h0040, 1'b0);
        adv(1'b0, 1'b0, 16'h0000);
        adv(1'b0, 1'b0, 16'h0000);
        adv(1'b0, 1'b0, 16'h0000);
        chk_out("rp0", 1'b1, 16'h0040, 16'hA5E5);
        chk("rp0.rom_en", 32'(rom_en), 32'd0);
        #1 rst_n = 1'b0;
        #1 chk_zero("rp1");
        #1 rst_n = 1'b1;
        adv(1'b1, 1'b0, 16'h0000);
        chk("rp2.valid",    32'(instr_valid), 32'd0);
        chk("rp2.rom_addr", 32'(rom_addr),    32'h0043);
        adv(1'b1, 1'b0, 16'h0000);
        chk_out("rp3", 1'b1, 16'h0042, 16'hA5E7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the fetch-queue entries (legal range 2..4).
REQ-002 SHALL have parameter ROM_ADDR_W, default 15, meaning the instruction-ROM address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 pc_i  input  16  current program-counter value, taken from the PC block's out_o.
REQ-007 pc_inc_o  output  1  advance request, driving the PC block's inc_i.
REQ-008 flush_i  input  1  jump taken; asserted in the same cycle the PC block's load_i is asserted.
REQ-009 rom_en_o  output  1  ROM read strobe.
REQ-010 rom_addr_o  output  ROM_ADDR_W  ROM read address.
REQ-011 rom_data_i  input  16  ROM read data, valid exactly 1 cycle after rom_en_o.
REQ-012 instr_o  output  16  head-of-queue instruction.
REQ-013 instr_pc_o  output  16  PC of instr_o.
REQ-014 instr_valid_o  output  1  instr_o/instr_pc_o valid.
REQ-015 instr_ready_i  input  1  consumer accepts the head entry.

Function
REQ-016 Issue condition SHALL be: issue = !flush_i && (count + inflight - pop) < DEPTH, where pop = instr_valid_o && instr_ready_i.
REQ-017 On issue: rom_en_o=1, pc_inc_o=1, rom_addr_o=pc_i[ROM_ADDR_W-1:0]; register pc_i as the in-flight PC; set inflight=1 at the next edge.
REQ-018 When no issue occurs: rom_en_o=0, pc_inc_o=0, rom_addr_o holds its last value.
REQ-019 An in-flight read SHALL push {in-flight PC, rom_data_i} into the queue on the cycle after issue, then clear inflight unless a new issue occurs.
REQ-020 instr_valid_o SHALL be (count != 0) && !flush_i; instr_o/instr_pc_o SHALL show the head entry, zero when empty.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged, and data order SHALL be preserved.
REQ-022 Full throughput SHALL be sustained: with instr_ready_i held high, one instruction per cycle after a 2-cycle initial latency (issue -> push -> visible).
REQ-023 flush_i SHALL empty the queue and kill any in-flight read (no push on the next cycle); pop is ignored that cycle.
REQ-024 Fetching SHALL resume the cycle after flush_i, from the newly loaded pc_i.
REQ-025 count SHALL never exceed DEPTH and never go below 0; a pop when empty is impossible by construction.
REQ-026 PC wrap 0xFFFF -> 0x0000 is the PC block's job; rom_addr_o truncates to the low ROM_ADDR_W bits, and instr_pc_o carries the full 16 bits.

Reset
REQ-027 While rst_ni=0: count=0, inflight=0, queue pointers=0, in-flight PC=0; all outputs 0, including rom_addr_o.
REQ-028 Reset asserted mid-operation SHALL discard all queued and in-flight data immediately, without waiting for a clock edge.
REQ-029 The first issue SHALL occur on the first rising edge after rst_ni deasserts.

Structure
REQ-030 hack_pkg SHALL hold WORD_W=16, ROM_ADDR_W=15, FETCH_DEPTH=2 and the queue-entry struct {pc, instr}.
REQ-031 The queue SHALL be one sub-module, fetch_fifo (DEPTH entries, push/pop/clear, count output); issue logic and the in-flight register stay in instr_fetch.

Verification
REQ-032 Reset release, ROM[n]=n^16'hA5A5, pc starting at 0, ready=1 -> instr_valid_o from cycle 2; instr_pc_o sequence 0,1,2,3..., one per cycle, with matching instr_o.
REQ-033 ready=0 for 5 cycles -> count saturates at 2, pc_inc_o drops to 0, rom_en_o stays 0; ready=1 -> entries PC 0,1 delivered in order, then fetching resumes.
REQ-034 flush_i at PC 5 with the PC loading 0x0100 -> instr_valid_o=0 that cycle; next delivered instr_pc_o=0x0100 and no stale PC 4/5/6 appears.
REQ-035 flush_i asserted at the same time as a push and a pop -> queue empty afterwards; the in-flight entry never appears on the output.
REQ-036 PC=0x7FFF/0xFFFF then wrap -> rom_addr_o=0x7FFF, 0x7FFF, 0x0000; instr_pc_o=0x7FFF, 0xFFFF, 0x0000.
REQ-037 rst_ni pulsed low between edges while count=2 -> outputs 0 immediately; after release the fetch restarts from pc_i with a clean queue.
